// File: rtl/uart_rx_word.sv
// 8N1 UART receiver that packs up to eight bytes (LSB first) into a 64-bit word.
// Short words are committed after an inter-byte idle timeout with upper bytes zero.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// st_idle  | line idle, waiting for a start edge; runs the idle timeout
// st_start | validating the start bit at mid-bit
// st_data  | sampling 8 data bits at mid-bit, LSB first
// st_stop  | sampling the stop bit; stores byte or flags a framing error
// st_break | framing error seen; wait for the line to return high
module uart_rx_word #(
  parameter int clk_per_bit  = 434,
  parameter int timeout_bits = 20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_serial,
  output logic [63:0] rx_word,
  output logic        rx_valid,
  output logic [3:0]  rx_nbytes,
  output logic        rx_busy,
  output logic        frame_err
);

  localparam int cnt_w      = $clog2(clk_per_bit);
  localparam int idle_total = timeout_bits * clk_per_bit;
  localparam int idle_w     = $clog2(idle_total);

  localparam logic [cnt_w-1:0]  half_bit  = cnt_w'((clk_per_bit - 1) / 2);
  localparam logic [cnt_w-1:0]  full_bit  = cnt_w'(clk_per_bit - 1);
  localparam logic [cnt_w-1:0]  cnt_one   = cnt_w'(1);
  localparam logic [idle_w-1:0] idle_last = idle_w'(idle_total - 1);
  localparam logic [idle_w-1:0] idle_one  = idle_w'(1);

  localparam logic [2:0] st_idle  = 3'd0;
  localparam logic [2:0] st_start = 3'd1;
  localparam logic [2:0] st_data  = 3'd2;
  localparam logic [2:0] st_stop  = 3'd3;
  localparam logic [2:0] st_break = 3'd4;

  logic              sync_1;
  logic              rx_s;
  logic [2:0]        state;
  logic [cnt_w-1:0]  clk_count;
  logic [2:0]        bit_idx;
  logic [2:0]        byte_idx;
  logic [7:0]        shreg;
  logic [63:0]       acc;
  logic [idle_w-1:0] idle_cnt;
  logic              timeout_hit;

  assign timeout_hit = (state == st_idle) && (byte_idx != 3'd0) && (idle_cnt == idle_last);

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_1 <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      sync_1 <= rx_serial;
      rx_s   <= sync_1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= st_idle;
      clk_count <= '0;
      bit_idx   <= 3'd0;
      byte_idx  <= 3'd0;
      shreg     <= 8'h00;
      acc       <= 64'h0;
      idle_cnt  <= '0;
      rx_word   <= 64'h0;
      rx_valid  <= 1'b0;
      rx_nbytes <= 4'd0;
      rx_busy   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;

      // Timeout commit is independent of start detection so both can fire together.
      if (timeout_hit) begin
        rx_word   <= acc;
        rx_nbytes <= {1'b0, byte_idx};
        rx_valid  <= 1'b1;
        acc       <= 64'h0;
        byte_idx  <= 3'd0;
        idle_cnt  <= '0;
      end else if ((state == st_idle) && (byte_idx != 3'd0)) begin
        idle_cnt <= idle_cnt + idle_one;
      end

      case (state)
        st_idle: begin
          if (!rx_s) begin
            clk_count <= '0;
            rx_busy   <= 1'b1;
            state     <= st_start;
          end
        end

        st_start: begin
          if (clk_count == half_bit) begin
            clk_count <= '0;
            if (!rx_s) begin
              bit_idx <= 3'd0;
              state   <= st_data;
            end else begin
              rx_busy <= 1'b0;
              state   <= st_idle;
            end
          end else begin
            clk_count <= clk_count + cnt_one;
          end
        end

        st_data: begin
          if (clk_count == full_bit) begin
            clk_count <= '0;
            shreg     <= {rx_s, shreg[7:1]};
            if (bit_idx == 3'd7) begin
              state <= st_stop;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            clk_count <= clk_count + cnt_one;
          end
        end

        st_stop: begin
          if (clk_count == full_bit) begin
            clk_count <= '0;
            rx_busy   <= 1'b0;
            idle_cnt  <= '0;
            if (rx_s) begin
              if (byte_idx == 3'd7) begin
                rx_word   <= {shreg, acc[55:0]};
                rx_nbytes <= 4'd8;
                rx_valid  <= 1'b1;
                acc       <= 64'h0;
                byte_idx  <= 3'd0;
              end else begin
                acc[{byte_idx, 3'b000} +: 8] <= shreg;
                byte_idx <= byte_idx + 3'd1;
              end
              // Leaving half a bit early lets a back-to-back start bit be caught.
              state <= st_idle;
            end else begin
              frame_err <= 1'b1;
              acc       <= 64'h0;
              byte_idx  <= 3'd0;
              state     <= st_break;
            end
          end else begin
            clk_count <= clk_count + cnt_one;
          end
        end

        st_break: begin
          if (rx_s) begin
            state <= st_idle;
          end
        end

        default: begin
          state <= st_idle;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_rx_word.md
# uart_rx_word

Receive-side counterpart of the UART transmitter in the threshold-scan link: deserialises 8N1 frames at `clk_per_bit` clocks per bit and assembles up to eight bytes, least-significant byte first, into a 64-bit word. The transmitter drops trailing all-zero upper bytes, so an inter-byte idle timeout commits short words with their upper bytes zero-filled. Output is a one-cycle `rx_valid` strobe with the word, consumed by the scan command decoder.

## Interface

- `clk_per_bit`, 434: clock cycles per bit (clk_freq / baud_rate; 50 MHz at 115200 baud).
- `timeout_bits`, 20: idle bit periods after a stop bit before a partial word is committed.
- `clock`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rx_serial`  in  1  asynchronous serial line; idles high.
- `rx_word`  out  64  assembled word; valid while `rx_valid`=1, held until the next commit.
- `rx_valid`  out  1  one-cycle pulse: `rx_word` updated.
- `rx_nbytes`  out  4  byte count of the committed word (1..8), updated with `rx_valid`.
- `rx_busy`  out  1  high from start-bit detection to stop-bit sample.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.

## Operation

- Input synchroniser: two flops, both reset to 1. All decisions use the second-flop output `rx_s`.
- Bit counter `clk_count`: $clog2(clk_per_bit) bits. Byte index `byte_idx`: 0..7. Shift register `shreg` [7:0]. Accumulator `acc` [63:0]. Idle counter `idle_cnt`: wide enough for timeout_bits*clk_per_bit.
- States:
  - IDLE: `rx_s`=0 → clear `clk_count`, go to START, `rx_busy`=1.
  - START: count to (clk_per_bit-1)/2 (216 at default). At that count, `rx_s`=0 → clear `clk_count`, bit=0, go to DATA. `rx_s`=1 → glitch: go to IDLE, `rx_busy`=0, no other effect.
  - DATA: count to clk_per_bit-1, then sample `rx_s` into `shreg` LSB-first (right shift, new bit into [7]). Repeat for 8 bits, then go to STOP.
  - STOP: count to clk_per_bit-1, then sample.
    - `rx_s`=1 → `acc[8*byte_idx +: 8]` <= `shreg`.
    - If `byte_idx`=7, commit: `rx_word` <= completed acc, `rx_nbytes`=8, `rx_valid` pulse, `acc` and `byte_idx` cleared. Otherwise `byte_idx`++ and `idle_cnt` cleared.
    - Either way go to IDLE, `rx_busy`=0.
    - `rx_s`=0 → `frame_err` pulse; discard `acc`, `byte_idx`=0; go to BREAK.
  - BREAK: wait for `rx_s`=1, then go to IDLE. No start detection while in BREAK.
- Timeout: in IDLE with `byte_idx`>0, `idle_cnt` increments every cycle. Reaching timeout_bits*clk_per_bit-1 commits: `rx_word` <= `acc` (unwritten bytes zero), `rx_nbytes`=`byte_idx`, `rx_valid` pulse, then `acc` and `byte_idx` cleared.
- Simultaneous timeout expiry and start-edge detection in the same cycle: both take effect. The partial word commits and START begins; the new byte lands at index 0.
- Reset (any state, mid-frame included): state IDLE, `rx_word`=0, `rx_nbytes`=0, `rx_valid`=0, `rx_busy`=0, `frame_err`=0, counters, `acc` and `shreg` cleared. No partial word is ever emitted on reset.

## Timing

- Synchroniser latency: 2 cycles from `rx_serial` edge to `rx_s`.
- Sample points relative to start-edge detection:
  - start bit at +216 cycles;
  - data bit k at +216+434*(k+1);
  - stop bit at +216+434*9 = 4122.
- `rx_valid` (8th byte) and `frame_err` assert the cycle after the stop-bit sample; each is exactly 1 cycle wide.
- Back-to-back frames: IDLE is re-entered half a bit before the stop-bit end, so a start bit immediately following is detected with no lost frame.
- Timeout commit: timeout_bits*clk_per_bit cycles (8680) after the last stop-bit sample.
- Baud tolerance: sampling at mid-bit tolerates ±4% clock mismatch across a frame.

## Test plan

- Reset, then 8 frames 0x11..0x88 back-to-back → single `rx_valid`, `rx_word`=64'h8877665544332211, `rx_nbytes`=8, no `frame_err`.
- 2 frames 0x34, 0x12, then idle → `rx_valid` exactly 8680 cycles after the second stop sample; `rx_word`=64'h1234, `rx_nbytes`=2.
- Frame with stop bit forced 0 after 3 good bytes, line held low 2000 cycles, then 8 good frames → `frame_err` pulse; partial word discarded; next `rx_valid` carries only the 8 new bytes.
- 100-cycle low glitch on an idle line → returns to IDLE, no `rx_valid`/`frame_err`, `rx_busy` high only during the glitch window.
- `reset` asserted mid-DATA of byte 4 → all outputs 0 next cycle; a subsequent 8-byte burst decodes correctly from byte index 0.
- Loopback with the transmitter sending 64'h00000000_0000A5C3 (2 bytes on the wire) → `rx_word`=64'hA5C3, `rx_nbytes`=2.
